// File: rtl/ins_dispatch_arbiter.sv
// Command dispatcher: decodes the target unit, holds the command while that unit is busy, then issues it.
// Optional watchdog on WAIT_UNIT/SYNC is built when DISPATCH_TIMEOUT_EN is defined.
//
// state       | meaning
// S_IDLE      | ready for a command strobe
// S_WAIT_UNIT | held command waits for its target unit to go idle
// S_ISSUE     | unit_start/unit_cmd presented to the target unit
// S_SYNC      | sync command waits for every unit to go idle
// S_ACK       | done_ins pulse to the controller
module ins_dispatch_arbiter #(
    parameter int NUM_UNITS    = 4,
    parameter int CMD_W        = 40,
    parameter int UNIT_SEL_LSB = 5,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CMD_W-1:0]     cmd_in,
    input  logic                 cmd_we,
    output logic                 done_ins,
    output logic [CMD_W-1:0]     unit_cmd,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic                 err
);

    localparam int SELW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_UNIT,
        S_ISSUE,
        S_SYNC,
        S_ACK
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CMD_W-1:0]     r_cmd;
    logic [CMD_W-1:0]     r_unit_cmd;
    logic [NUM_UNITS-1:0] r_start;
    logic [NUM_UNITS-1:0] r_busy;
    logic                 r_done_ins;
    logic                 r_err;

    logic [CMD_W-1:0]     w_cmd;
    logic [4:0]           w_opcode;
    logic [SELW-1:0]      w_unit;
    logic                 w_sync;
    logic                 w_unit_bad;
    logic                 w_real_op;
    logic                 w_nop;
    logic [NUM_UNITS-1:0] w_onehot;
    logic                 w_tgt_busy;
    logic                 w_tgt_done;
    logic                 w_in_wait;
    logic                 w_timeout;
    logic                 w_err_set;

    // In IDLE the decision is made on the incoming command, afterwards on the held copy.
    assign w_cmd      = (r_state == S_IDLE) ? cmd_in : r_cmd;
    assign w_opcode   = w_cmd[4:0];
    assign w_unit     = w_cmd[UNIT_SEL_LSB +: SELW];
    assign w_sync     = w_cmd[CMD_W-1];
    assign w_unit_bad = ({1'b0, w_unit} >= (SELW+1)'(NUM_UNITS));
    assign w_real_op  = (w_opcode != 5'h00) && (w_opcode != 5'h1F);
    assign w_nop      = !w_real_op || w_unit_bad;
    assign w_onehot   = w_unit_bad ? '0 : ({{(NUM_UNITS-1){1'b0}}, 1'b1} << w_unit);
    assign w_tgt_busy = |(r_busy & w_onehot);
    assign w_tgt_done = |(unit_done & w_onehot);
    assign w_in_wait  = (r_state == S_WAIT_UNIT) || (r_state == S_SYNC);

`ifdef DISPATCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wdog;
    logic [TIMEOUT_W-1:0] w_wdog_inc;

    assign w_wdog_inc = r_wdog + TIMEOUT_W'(1);
    assign w_timeout  = w_in_wait && (&w_wdog_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (w_in_wait && !w_timeout) begin
            r_wdog <= w_wdog_inc;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_we) begin
                    if (w_nop)
                        w_state_nxt = w_sync ? S_SYNC : S_ACK;
                    else if (w_tgt_busy && !w_tgt_done)
                        w_state_nxt = S_WAIT_UNIT;
                    else
                        w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT_UNIT: begin
                if (w_timeout)
                    w_state_nxt = S_ACK;
                else if (!w_tgt_busy || w_tgt_done)
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE:  w_state_nxt = w_sync ? S_SYNC : S_ACK;
            S_SYNC: begin
                if (w_timeout || ((r_busy & ~unit_done) == '0))
                    w_state_nxt = S_ACK;
            end
            S_ACK:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Stray completions, strobes outside IDLE, bad unit indices and watchdog expiry are all sticky errors.
    assign w_err_set = (|(unit_done & ~r_busy))
                     || (cmd_we && (r_state != S_IDLE))
                     || (cmd_we && (r_state == S_IDLE) && w_real_op && w_unit_bad)
                     || w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_unit_cmd <= '0;
            r_start    <= '0;
            r_busy     <= '0;
            r_done_ins <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if ((r_state == S_IDLE) && cmd_we)
                r_cmd <= cmd_in;
            if (w_state_nxt == S_ISSUE) begin
                r_start    <= w_onehot;
                r_unit_cmd <= w_cmd;
            end else begin
                r_start    <= '0;
            end
            r_busy     <= w_timeout ? '0 : ((r_busy & ~unit_done) | r_start);
            r_done_ins <= (w_state_nxt == S_ACK);
            r_err      <= r_err || w_err_set;
        end
    end

    assign done_ins   = r_done_ins;
    assign unit_cmd   = r_unit_cmd;
    assign unit_start = r_start;
    assign unit_busy  = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_ins_dispatch_arbiter.sv
// Directed bench for ins_dispatch_arbiter (default build, NUM_UNITS=4): vector table plus hand-written corner sequences.
module tb_ins_dispatch_arbiter;

    logic        clk;
    logic        rst;
    logic [39:0] cmd_in;
    logic        cmd_we;
    logic        done_ins;
    logic [39:0] unit_cmd;
    logic [3:0]  unit_start;
    logic [3:0]  unit_done;
    logic [3:0]  unit_busy;
    logic        err;

    int total;
    int bad;

    ins_dispatch_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_in     (cmd_in),
        .cmd_we     (cmd_we),
        .done_ins   (done_ins),
        .unit_cmd   (unit_cmd),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .unit_busy  (unit_busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [39:0] cmd;
        logic [3:0]  done;
        logic [3:0]  e_start;
        logic [39:0] e_ucmd;
        logic        e_dins;
        logic [3:0]  e_busy;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic we, input logic [39:0] cmd, input logic [3:0] done,
                       input logic [3:0] st, input logic [39:0] ucmd, input logic dins,
                       input logic [3:0] busy);
        vec_t v;
        v.we = we; v.cmd = cmd; v.done = done;
        v.e_start = st; v.e_ucmd = ucmd; v.e_dins = dins; v.e_busy = busy;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [39:0] cmd, input logic [3:0] done);
        @(negedge clk);
        cmd_we = we; cmd_in = cmd; unit_done = done;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_we = 1'b0; cmd_in = '0; unit_done = '0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 40'(unit_start), 40'h0);
        chk({tag, "_busy"},  40'(unit_busy),  40'h0);
        chk({tag, "_dins"},  40'(done_ins),   40'h0);
        chk({tag, "_err"},   40'(err),        40'h0);
        chk({tag, "_ucmd"},  unit_cmd,        40'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; cmd_we = 1'b0; cmd_in = '0; unit_done = '0;

        // single issue, completion
        add(1, 40'h43, 4'b0000, 4'b0100, 40'h43, 0, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 1, 4'b0100);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 0, 4'b0100);
        add(0, 40'h0,  4'b0100, 4'b0000, 40'h43, 0, 4'b0000);
        // overlap two units
        add(1, 40'h43, 4'b0000, 4'b0100, 40'h43, 0, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 1, 4'b0100);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 0, 4'b0100);
        add(1, 40'h23, 4'b0000, 4'b0010, 40'h23, 0, 4'b0100);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h23, 1, 4'b0110);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h23, 0, 4'b0110);
        // same unit again: held in WAIT_UNIT
        add(1, 40'h43, 4'b0000, 4'b0000, 40'h23, 0, 4'b0110);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h23, 0, 4'b0110);
        add(0, 40'h0,  4'b0100, 4'b0100, 40'h43, 0, 4'b0010);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 1, 4'b0110);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 0, 4'b0110);
        // sync NOP waits for all units
        add(1, 40'h80_0000_0000, 4'b0000, 4'b0000, 40'h43, 0, 4'b0110);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 0, 4'b0110);
        add(0, 40'h0,  4'b0010, 4'b0000, 40'h43, 0, 4'b0100);
        add(0, 40'h0,  4'b0100, 4'b0000, 40'h43, 1, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 0, 4'b0000);
        // busy target finishing in the strobe cycle issues directly
        add(1, 40'h43, 4'b0000, 4'b0100, 40'h43, 0, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 1, 4'b0100);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 0, 4'b0100);
        add(1, 40'h45, 4'b0100, 4'b0100, 40'h45, 0, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h45, 1, 4'b0100);
        add(0, 40'h0,  4'b0100, 4'b0000, 40'h45, 0, 4'b0000);
        // END opcode acknowledged without a start
        add(1, 40'h1F, 4'b0000, 4'b0000, 40'h45, 1, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h45, 0, 4'b0000);
        // sync command to unit 3
        add(1, 40'h80_0000_0063, 4'b0000, 4'b1000, 40'h80_0000_0063, 0, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h80_0000_0063, 0, 4'b1000);
        add(0, 40'h0,  4'b1000, 4'b0000, 40'h80_0000_0063, 1, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h80_0000_0063, 0, 4'b0000);
        // start of one unit coincides with done of another
        add(1, 40'h43, 4'b0000, 4'b0100, 40'h43, 0, 4'b0000);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 1, 4'b0100);
        add(0, 40'h0,  4'b0000, 4'b0000, 40'h43, 0, 4'b0100);
        add(1, 40'h23, 4'b0000, 4'b0010, 40'h23, 0, 4'b0100);
        add(0, 40'h0,  4'b0100, 4'b0000, 40'h23, 1, 4'b0010);
        add(0, 40'h0,  4'b0010, 4'b0000, 40'h23, 0, 4'b0000);

        do_reset();
        #1;
        chk_all_zero("reset");

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].we, tv[i].cmd, tv[i].done);
            chk($sformatf("v%0d_start", i), 40'(unit_start), 40'(tv[i].e_start));
            chk($sformatf("v%0d_ucmd", i),  unit_cmd,        tv[i].e_ucmd);
            chk($sformatf("v%0d_dins", i),  40'(done_ins),   40'(tv[i].e_dins));
            chk($sformatf("v%0d_busy", i),  40'(unit_busy),  40'(tv[i].e_busy));
            chk($sformatf("v%0d_err", i),   40'(err),        40'h0);
        end

        // strobe during ISSUE is dropped and flags err
        drive(1, 40'h43, 4'b0000);
        chk("iss_start", 40'(unit_start), 40'h4);
        drive(1, 40'h23, 4'b0000);
        chk("iss_drop_err",  40'(err),      40'h1);
        chk("iss_drop_dins", 40'(done_ins), 40'h1);
        drive(0, 40'h0, 4'b0000);
        chk("iss_drop_nostart0", 40'(unit_start), 40'h0);
        drive(0, 40'h0, 4'b0000);
        chk("iss_drop_nostart1", 40'(unit_start), 40'h0);
        chk("iss_drop_busy",     40'(unit_busy),  40'h4);

        // stray completion on an idle unit
        do_reset();
        #1;
        chk("rst2_err", 40'(err), 40'h0);
        drive(0, 40'h0, 4'b1000);
        chk("stray_err",  40'(err),       40'h1);
        chk("stray_busy", 40'(unit_busy), 40'h0);
        drive(0, 40'h0, 4'b0000);
        chk("stray_sticky", 40'(err), 40'h1);

        // reset asserted while in WAIT_UNIT clears outputs at once
        do_reset();
        drive(1, 40'h43, 4'b0000);
        drive(0, 40'h0,  4'b0000);
        drive(0, 40'h0,  4'b0000);
        drive(1, 40'h43, 4'b0000);
        drive(0, 40'h0,  4'b0000);
        chk("wait_nostart", 40'(unit_start), 40'h0);
        chk("wait_busy",    40'(unit_busy),  40'h4);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        cmd_we = 1'b0; unit_done = '0;
        rst = 1'b1;
        drive(0, 40'h0, 4'b0100);
        chk("late_done_err",  40'(err),       40'h1);
        chk("late_done_busy", 40'(unit_busy), 40'h0);
        drive(1, 40'h23, 4'b0000);
        chk("post_rst_start", 40'(unit_start), 40'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ins_dispatch_arbiter.md
Name: ins_dispatch_arbiter

Overview:
- Sits between the program controller's command outputs (40-bit command, write strobe) and up to NUM_UNITS independent compute units.
- Decodes the target unit from each command, holds the command while that unit is busy, then issues it.
- Reports per-instruction completion back to the controller on its done_ins_computation input.
- Commands to different units overlap: a non-sync command is acknowledged as soon as it issues. A sync command is acknowledged only when every unit is idle.

Parameters:
- NUM_UNITS, 4, number of compute units (2..8).
- CMD_W, 40, command width.
- UNIT_SEL_LSB, 5, LSB of the unit-select field in the command; field width is SELW = clog2(NUM_UNITS).
- TIMEOUT_W, 16, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_in  in  CMD_W  command from the program controller; sampled only when cmd_we=1.
- cmd_we  in  1  one-cycle command strobe.
- done_ins  out  1  one-cycle acknowledge to the controller.
- unit_cmd  out  CMD_W  command bus broadcast to all units; valid while a unit_start bit is high.
- unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse.
- unit_done  in  NUM_UNITS  per-unit one-cycle completion pulse.
- unit_busy  out  NUM_UNITS  per-unit outstanding flag.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; held command=0; unit_cmd=0; unit_start=0; unit_busy=0; done_ins=0; err=0; watchdog=0.
- Decode:
  - opcode = cmd[4:0]; unit = cmd[UNIT_SEL_LSB +: SELW]; sync = cmd[CMD_W-1].
  - opcode 5'h00 (NOP) and 5'h1F (END) never issue to a unit. They go IDLE -> ACK, or IDLE -> SYNC if sync=1.
  - A unit index >= NUM_UNITS sets err and is treated as a NOP.
- States:
  - IDLE:
    - cmd_we=1: latch cmd_in.
    - NOP/END: go to ACK, or to SYNC if sync=1.
    - Target unit busy, with its unit_done not high in the same cycle: go to WAIT_UNIT.
    - Otherwise: go to ISSUE.
  - WAIT_UNIT: stay until unit_busy[unit]=0 or unit_done[unit]=1, then go to ISSUE.
  - ISSUE:
    - Registered outputs: unit_start[unit]=1 and unit_cmd=held command for exactly this cycle.
    - unit_busy[unit] is set at the end of this cycle.
    - Next state: SYNC if sync=1, else ACK.
  - SYNC: wait until (unit_busy & ~unit_done)==0, then go to ACK.
  - ACK: done_ins=1 for one cycle, then go to IDLE.
- Latency: cmd_we in cycle N with the target idle gives unit_start in N+1, done_ins in N+2, and IDLE (able to accept a command) in N+3.
- unit_busy rules:
  - Bit i is set by unit_start[i] and cleared by unit_done[i].
  - unit_done[i] while busy[i]=0: ignored; sets err.
  - Different units may start and finish in the same cycle without interference.
- cmd_we outside IDLE: the command is dropped, err is set, and the state is unchanged.
- unit_cmd holds its last value between starts; units must qualify it with unit_start.
- Reset asserted mid-operation clears everything immediately. Pending unit_done pulses arriving after reset release are ignored and set err.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit watchdog counts each cycle spent in WAIT_UNIT or SYNC and clears on any other state.
  - When it reaches all-ones: set err, clear all unit_busy bits, and go directly to ACK. The controller is released.
- Undefined: no counter is built; WAIT_UNIT and SYNC wait indefinitely; TIMEOUT_W is unused.

Test Plan (NUM_UNITS=4, UNIT_SEL_LSB=5):
1. Reset, then cmd_in=40'h0000000043 (opcode 3, unit 2) with cmd_we at cycle N -> unit_start=4'b0100 at N+1, unit_cmd=40'h43, done_ins at N+2, unit_busy=4'b0100. Then unit_done=4'b0100 -> busy returns to 0.
2. Issue 40'h43 (unit 2), then 40'h23 (unit 1) while unit 2 is still busy -> second start 4'b0010 issues without waiting; unit_busy=4'b0110.
3. Unit 2 busy; send 40'h43 again -> held in WAIT_UNIT with no start. Pulse unit_done[2] at cycle M -> unit_start=4'b0100 at M+1.
4. Units 1 and 2 busy; send sync NOP 40'h8000000000 -> done_ins withheld. Pulse done[1], then done[2] at cycle K -> done_ins at K+1.
5. Pulse cmd_we during ISSUE -> err=1, command ignored. Pulse unit_done[3] while unit 3 idle -> err=1. Drive rst=0 mid-WAIT_UNIT -> all outputs 0 in that same cycle.
6. With DISPATCH_TIMEOUT_EN and TIMEOUT_W=4: unit 0 busy and never done; send 40'h03 -> after 15 WAIT_UNIT cycles, err=1, unit_busy=0, done_ins pulses.
